// File: rtl/vx_gpu_csr_arbiter.sv
// Round-robin arbiter sharing one CSR slave; a request handshaken at N reaches the CSR port at N+1, and read data lands in the response buffer at N+2.
// Writes never stall; reads wait while a read is in flight or while the response buffer holds data that is not being drained.
module vx_gpu_csr_arbiter #(
   parameter int NUM_REQS    = 4,
   parameter int NUM_THREADS = 4,
   parameter int NW_BITS     = 2,
   parameter int UUID_BITS   = 8,
   parameter int ADDR_BITS   = 12,
   parameter int IDX_BITS    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic [NUM_REQS-1:0]                         req_valid,
   input  logic [NUM_REQS-1:0]                         req_rw,
   input  logic [NUM_REQS-1:0][UUID_BITS-1:0]          req_uuid,
   input  logic [NUM_REQS-1:0][NW_BITS-1:0]            req_wid,
   input  logic [NUM_REQS-1:0][NUM_THREADS-1:0]        req_tmask,
   input  logic [NUM_REQS-1:0][ADDR_BITS-1:0]          req_addr,
   input  logic [NUM_REQS-1:0][NUM_THREADS-1:0][31:0]  req_data,
   output logic [NUM_REQS-1:0]                         req_ready,
   output logic                                        csr_read_enable,
   output logic [UUID_BITS-1:0]                        csr_read_uuid,
   output logic [NW_BITS-1:0]                          csr_read_wid,
   output logic [NUM_THREADS-1:0]                      csr_read_tmask,
   output logic [ADDR_BITS-1:0]                        csr_read_addr,
   input  logic [NUM_THREADS-1:0][31:0]                csr_read_data,
   output logic                                        csr_write_enable,
   output logic [UUID_BITS-1:0]                        csr_write_uuid,
   output logic [NW_BITS-1:0]                          csr_write_wid,
   output logic [NUM_THREADS-1:0]                      csr_write_tmask,
   output logic [ADDR_BITS-1:0]                        csr_write_addr,
   output logic [NUM_THREADS-1:0][31:0]                csr_write_data,
   output logic                                        rsp_valid,
   output logic [IDX_BITS-1:0]                         rsp_idx,
   output logic [UUID_BITS-1:0]                        rsp_uuid,
   output logic [NW_BITS-1:0]                          rsp_wid,
   output logic [NUM_THREADS-1:0][31:0]                rsp_data,
   input  logic                                        rsp_ready
);

   logic [IDX_BITS-1:0]              rr_ptr;
   logic                             stage_valid;
   logic                             stage_rw;
   logic [IDX_BITS-1:0]              stage_idx;
   logic [UUID_BITS-1:0]             stage_uuid;
   logic [NW_BITS-1:0]               stage_wid;
   logic [NUM_THREADS-1:0]           stage_tmask;
   logic [ADDR_BITS-1:0]             stage_addr;
   logic [NUM_THREADS-1:0][31:0]     stage_data;

   logic                             read_ok;
   logic [NUM_REQS-1:0]              elig;
   logic                             grant_vld;
   logic [IDX_BITS-1:0]              grant_idx;
   logic [IDX_BITS-1:0]              cand;
   int                               pos;

   // A read may only go out once the buffer is guaranteed free when its data arrives.
   assign read_ok = !(stage_valid && !stage_rw) && (!rsp_valid || rsp_ready);
   assign elig    = req_valid & (req_rw | {NUM_REQS{read_ok}});

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      pos       = 0;
      for (int k = 0; k < NUM_REQS; k++) begin
         pos = int'(rr_ptr) + k;
         if (pos >= NUM_REQS) pos = pos - NUM_REQS;
         cand = IDX_BITS'(pos);
         if (!grant_vld && elig[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant_vld && reset) req_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr      <= '0;
         stage_valid <= 1'b0;
         stage_rw    <= 1'b0;
         stage_idx   <= '0;
         stage_uuid  <= '0;
         stage_wid   <= '0;
         stage_tmask <= '0;
         stage_addr  <= '0;
         stage_data  <= '0;
      end else begin
         stage_valid <= grant_vld;
         if (grant_vld) begin
            rr_ptr      <= (grant_idx == IDX_BITS'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
            stage_rw    <= req_rw[grant_idx];
            stage_idx   <= grant_idx;
            stage_uuid  <= req_uuid[grant_idx];
            stage_wid   <= req_wid[grant_idx];
            stage_tmask <= req_tmask[grant_idx];
            stage_addr  <= req_addr[grant_idx];
            stage_data  <= req_data[grant_idx];
         end
      end
   end

   assign csr_read_enable  = stage_valid && !stage_rw;
   assign csr_read_uuid    = stage_uuid;
   assign csr_read_wid     = stage_wid;
   assign csr_read_tmask   = stage_tmask;
   assign csr_read_addr    = stage_addr;
   assign csr_write_enable = stage_valid && stage_rw;
   assign csr_write_uuid   = stage_uuid;
   assign csr_write_wid    = stage_wid;
   assign csr_write_tmask  = stage_tmask;
   assign csr_write_addr   = stage_addr;
   assign csr_write_data   = csr_write_enable ? stage_data : '0;

   // Capture and drain never coincide: read_ok only admitted the read after a drain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid <= 1'b0;
         rsp_idx   <= '0;
         rsp_uuid  <= '0;
         rsp_wid   <= '0;
         rsp_data  <= '0;
      end else if (csr_read_enable) begin
         rsp_valid <= 1'b1;
         rsp_idx   <= stage_idx;
         rsp_uuid  <= stage_uuid;
         rsp_wid   <= stage_wid;
         rsp_data  <= csr_read_data;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vx_gpu_csr_arbiter.sv
// Bench for vx_gpu_csr_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_vx_gpu_csr_arbiter;
   localparam int NR  = 4;
   localparam int NT  = 4;
   localparam int NWB = 2;
   localparam int UB  = 8;
   localparam int AB  = 12;
   localparam int IB  = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [NR-1:0]                req_valid, req_rw, req_ready;
   logic [NR-1:0][UB-1:0]        req_uuid;
   logic [NR-1:0][NWB-1:0]       req_wid;
   logic [NR-1:0][NT-1:0]        req_tmask;
   logic [NR-1:0][AB-1:0]        req_addr;
   logic [NR-1:0][NT-1:0][31:0]  req_data;
   logic                         csr_read_enable, csr_write_enable;
   logic [UB-1:0]                csr_read_uuid, csr_write_uuid;
   logic [NWB-1:0]               csr_read_wid, csr_write_wid;
   logic [NT-1:0]                csr_read_tmask, csr_write_tmask;
   logic [AB-1:0]                csr_read_addr, csr_write_addr;
   logic [NT-1:0][31:0]          csr_read_data, csr_write_data;
   logic                         rsp_valid, rsp_ready;
   logic [IB-1:0]                rsp_idx;
   logic [UB-1:0]                rsp_uuid;
   logic [NWB-1:0]               rsp_wid;
   logic [NT-1:0][31:0]          rsp_data;

   vx_gpu_csr_arbiter #(.NUM_REQS(NR), .NUM_THREADS(NT), .NW_BITS(NWB), .UUID_BITS(UB),
                        .ADDR_BITS(AB), .IDX_BITS(IB)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_rw(req_rw), .req_uuid(req_uuid), .req_wid(req_wid),
      .req_tmask(req_tmask), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
      .csr_read_enable(csr_read_enable), .csr_read_uuid(csr_read_uuid), .csr_read_wid(csr_read_wid),
      .csr_read_tmask(csr_read_tmask), .csr_read_addr(csr_read_addr), .csr_read_data(csr_read_data),
      .csr_write_enable(csr_write_enable), .csr_write_uuid(csr_write_uuid), .csr_write_wid(csr_write_wid),
      .csr_write_tmask(csr_write_tmask), .csr_write_addr(csr_write_addr), .csr_write_data(csr_write_data),
      .rsp_valid(rsp_valid), .rsp_idx(rsp_idx), .rsp_uuid(rsp_uuid), .rsp_wid(rsp_wid),
      .rsp_data(rsp_data), .rsp_ready(rsp_ready)
   );

   // CSR slave: one word per address, returned on every lane, lane 0 stored on write.
   logic [31:0]   slave_mem [0:4095];
   logic          pl_en = 1'b0;
   logic [AB-1:0] pl_addr = '0;
   logic [31:0]   pl_val = '0;
   always @(posedge clk) begin
      if (pl_en) slave_mem[pl_addr] <= pl_val;
      else if (csr_write_enable) slave_mem[csr_write_addr] <= csr_write_data[0];
   end
   always_comb begin
      for (int l = 0; l < NT; l++) csr_read_data[l] = slave_mem[csr_read_addr];
   end

   typedef struct {
      logic           rw;
      logic [IB-1:0]  idx;
      logic [UB-1:0]  uuid;
      logic [NWB-1:0] wid;
      logic [NT-1:0]  tmask;
      logic [AB-1:0]  addr;
      logic [NT-1:0][31:0] data;
   } access_t;
   typedef struct {
      logic [IB-1:0]  idx;
      logic [UB-1:0]  uuid;
      logic [NWB-1:0] wid;
      logic [31:0]    word;
   } rsp_t;

   access_t     port_q[$];
   rsp_t        rsp_q[$];
   logic [31:0] m_mem [0:15];
   int          m_ptr;
   int          checks = 0;
   int          failures = 0;
   logic [NR-1:0]       exp_rdy;
   logic [NT-1:0][31:0] exp_d;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      req_valid = '0; req_rw = '0; req_uuid = '0; req_wid = '0;
      req_tmask = '0; req_addr = '0; req_data = '0; rsp_ready = 1'b0;
   endtask

   task automatic set_req(input int i, input logic rw, input logic [AB-1:0] a, input logic [31:0] w,
                          input logic [UB-1:0] u, input logic [NWB-1:0] wd);
      req_valid[i] = 1'b1; req_rw[i] = rw; req_addr[i] = a; req_uuid[i] = u;
      req_wid[i] = wd; req_tmask[i] = '1;
      for (int l = 0; l < NT; l++) req_data[i][l] = w + 32'(l);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_reqs();
      repeat (2) next_cycle();
      reset = 1'b1;
   endtask

   task automatic preload(input logic [AB-1:0] a, input logic [31:0] v);
      pl_en = 1'b1; pl_addr = a; pl_val = v;
      next_cycle();
      pl_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_reqs();
      for (int i = 0; i < NR; i++) set_req(i, i[0], AB'(16 * i), 32'h0, 8'h0, 2'd0);
      rsp_ready = 1'b1;
      repeat (3) next_cycle();
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
      checks++; if (csr_read_enable !== 1'b0 || csr_write_enable !== 1'b0) begin failures++; $display("FAIL reset_enables got rd=%b wr=%b want 0", csr_read_enable, csr_write_enable); end
      checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0) begin failures++; $display("FAIL reset_rsp got valid=%b data=%h want 0", rsp_valid, rsp_data); end
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b want=0001", req_ready); end
      next_cycle();
      clear_reqs();
   endtask

   task automatic test_write_rr();
      int p;
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, AB'(12'h100 + i), 32'hA000_0000 + 32'(16 * i), UB'(i), NWB'(i));
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         exp_rdy = '0; exp_rdy[c % NR] = 1'b1;
         checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, req_ready, exp_rdy); end
         checks++; if (csr_write_enable !== (c >= 1) || csr_read_enable !== 1'b0) begin failures++; $display("FAIL rr_wr_en c=%0d got wr=%b rd=%b", c, csr_write_enable, csr_read_enable); end
         if (c >= 1) begin
            p = (c - 1) % NR;
            checks++;
            if (csr_write_addr !== AB'(12'h100 + p) || csr_write_data[1] !== 32'hA000_0001 + 32'(16 * p)) begin
               failures++; $display("FAIL rr_wr_payload c=%0d got addr=%h d1=%h want addr=%h", c, csr_write_addr, csr_write_data[1], 12'h100 + p);
            end
         end else begin
            checks++; if (csr_write_data !== '0) begin failures++; $display("FAIL wr_data_idle got=%h want 0", csr_write_data); end
         end
         next_cycle();
      end
      clear_reqs();
   endtask

   task automatic test_read_basic();
      do_reset();
      preload(12'h0C0, 32'hDEADBEEF);
      set_req(2, 1'b0, 12'h0C0, 32'h0, 8'h5A, 2'd2);
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0100 || csr_read_enable !== 1'b0) begin failures++; $display("FAIL rd_grant got=%b rd=%b want 0100/0", req_ready, csr_read_enable); end
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      checks++; if (csr_read_enable !== 1'b1 || csr_read_addr !== 12'h0C0 || csr_read_uuid !== 8'h5A || rsp_valid !== 1'b0) begin
         failures++; $display("FAIL rd_port got en=%b addr=%h uuid=%h rsp=%b", csr_read_enable, csr_read_addr, csr_read_uuid, rsp_valid); end
      next_cycle();
      @(negedge clk);
      exp_d = {NT{32'hDEADBEEF}};
      checks++; if (rsp_valid !== 1'b1 || rsp_idx !== 2'd2 || rsp_uuid !== 8'h5A || rsp_wid !== 2'd2 || rsp_data !== exp_d) begin
         failures++; $display("FAIL rd_rsp got v=%b idx=%0d uuid=%h data=%h", rsp_valid, rsp_idx, rsp_uuid, rsp_data); end
      next_cycle();
      clear_reqs();
   endtask

   task automatic test_backpressure();
      do_reset();
      preload(12'h030, 32'h1111_2222);
      preload(12'h040, 32'h3333_4444);
      set_req(3, 1'b0, 12'h030, 32'h0, 8'h33, 2'd3);
      rsp_ready = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL bp_first got=%b want=1000", req_ready); end
      next_cycle(); req_valid = '0;
      next_cycle();
      set_req(0, 1'b0, 12'h040, 32'h0, 8'h10, 2'd0);
      set_req(1, 1'b1, 12'h050, 32'hCAFE_0000, 8'h11, 2'd1);
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data[0] !== 32'h1111_2222) begin failures++; $display("FAIL bp_full got v=%b d=%h", rsp_valid, rsp_data[0]); end
      checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_write_first got=%b want=0010", req_ready); end
      next_cycle(); req_valid[1] = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000 || csr_write_enable !== 1'b1 || csr_write_addr !== 12'h050) begin
         failures++; $display("FAIL bp_stall got rdy=%b wr=%b addr=%h", req_ready, csr_write_enable, csr_write_addr); end
      checks++; if (rsp_idx !== 2'd3 || rsp_data[0] !== 32'h1111_2222) begin failures++; $display("FAIL bp_hold got idx=%0d d=%h", rsp_idx, rsp_data[0]); end
      next_cycle();
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_stall2 got=%b want=0000", req_ready); end
      next_cycle(); rsp_ready = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_release got=%b want=0001", req_ready); end
      next_cycle(); req_valid = '0;
      @(negedge clk);
      checks++; if (csr_read_enable !== 1'b1 || csr_read_addr !== 12'h040 || rsp_valid !== 1'b0) begin
         failures++; $display("FAIL bp_rd_port got en=%b addr=%h rsp=%b", csr_read_enable, csr_read_addr, rsp_valid); end
      next_cycle();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_idx !== 2'd0 || rsp_data[0] !== 32'h3333_4444) begin
         failures++; $display("FAIL bp_rsp got v=%b idx=%0d d=%h", rsp_valid, rsp_idx, rsp_data[0]); end
      next_cycle();
      clear_reqs();
   endtask

   task automatic test_write_then_read();
      do_reset();
      preload(12'h7C0, 32'h0);
      set_req(1, 1'b1, 12'h7C0, 32'h55, 8'h21, 2'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL wtr_wgrant got=%b want=0010", req_ready); end
      next_cycle();
      set_req(1, 1'b0, 12'h7C0, 32'h0, 8'h22, 2'd1);
      @(negedge clk);
      checks++; if (req_ready !== 4'b0010 || csr_write_enable !== 1'b1 || csr_write_addr !== 12'h7C0 || csr_write_data[0] !== 32'h55) begin
         failures++; $display("FAIL wtr_write got rdy=%b wr=%b addr=%h d=%h", req_ready, csr_write_enable, csr_write_addr, csr_write_data[0]); end
      next_cycle(); req_valid = '0;
      @(negedge clk);
      checks++; if (csr_read_enable !== 1'b1 || csr_read_addr !== 12'h7C0 || csr_write_enable !== 1'b0 || csr_write_data !== '0) begin
         failures++; $display("FAIL wtr_read got rd=%b addr=%h wr=%b", csr_read_enable, csr_read_addr, csr_write_enable); end
      next_cycle();
      @(negedge clk);
      exp_d = {NT{32'h55}};
      checks++; if (rsp_valid !== 1'b1 || rsp_idx !== 2'd1 || rsp_uuid !== 8'h22 || rsp_data !== exp_d) begin
         failures++; $display("FAIL wtr_rsp got v=%b idx=%0d data=%h want 55s", rsp_valid, rsp_idx, rsp_data); end
      next_cycle();
      clear_reqs();
   endtask

   task automatic test_reset_midflight();
      do_reset();
      set_req(2, 1'b0, 12'h0C0, 32'h0, 8'h77, 2'd2);
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL mid_grant got=%b want=0100", req_ready); end
      next_cycle();
      reset = 1'b0;
      req_valid = '0;
      set_req(0, 1'b1, 12'h010, 32'h0, 8'h0, 2'd0);
      @(negedge clk);
      checks++; if (csr_read_enable !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL mid_in_reset got rd=%b rdy=%b", csr_read_enable, req_ready); end
      next_cycle();
      reset = 1'b1;
      set_req(3, 1'b1, 12'h020, 32'h0, 8'h0, 2'd0);
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001 || rsp_valid !== 1'b0 || csr_read_enable !== 1'b0) begin
         failures++; $display("FAIL mid_after got rdy=%b rsp=%b rd=%b want 0001/0/0", req_ready, rsp_valid, csr_read_enable); end
      next_cycle(); req_valid = '0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || csr_read_enable !== 1'b0) begin failures++; $display("FAIL mid_no_rsp got rsp=%b rd=%b", rsp_valid, csr_read_enable); end
      next_cycle();
      clear_reqs();
   endtask

   task automatic test_random();
      access_t a;
      rsp_t    r;
      logic    exp_rd, exp_wr, exp_rv, read_ok;
      int      g, i;
      logic [31:0] v;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         v = $urandom;
         m_mem[k] = v;
         preload(AB'(k), v);
      end
      port_q.delete();
      rsp_q.delete();
      m_ptr = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int q = 0; q < NR; q++) begin
            req_valid[q] = ($urandom_range(0, 99) < 60);
            req_rw[q]    = 1'($urandom_range(0, 1));
            req_addr[q]  = AB'($urandom_range(0, 15));
            req_uuid[q]  = UB'($urandom);
            req_wid[q]   = NWB'($urandom);
            req_tmask[q] = NT'($urandom);
            for (int l = 0; l < NT; l++) req_data[q][l] = $urandom;
         end
         rsp_ready = ($urandom_range(0, 99) < 50);
         @(negedge clk);
         exp_rd = (port_q.size() != 0) && !port_q[0].rw;
         exp_wr = (port_q.size() != 0) && port_q[0].rw;
         checks++; if (csr_read_enable !== exp_rd || csr_write_enable !== exp_wr) begin
            failures++; $display("FAIL rnd_enables cyc=%0d got rd=%b wr=%b want rd=%b wr=%b", cyc, csr_read_enable, csr_write_enable, exp_rd, exp_wr); end
         if (exp_rd) begin
            checks++; if (csr_read_addr !== port_q[0].addr || csr_read_uuid !== port_q[0].uuid || csr_read_wid !== port_q[0].wid || csr_read_tmask !== port_q[0].tmask) begin
               failures++; $display("FAIL rnd_rd_payload cyc=%0d got addr=%h uuid=%h want addr=%h uuid=%h", cyc, csr_read_addr, csr_read_uuid, port_q[0].addr, port_q[0].uuid); end
         end
         if (exp_wr) begin
            checks++; if (csr_write_addr !== port_q[0].addr || csr_write_data !== port_q[0].data || csr_write_uuid !== port_q[0].uuid || csr_write_tmask !== port_q[0].tmask) begin
               failures++; $display("FAIL rnd_wr_payload cyc=%0d got addr=%h d0=%h want addr=%h d0=%h", cyc, csr_write_addr, csr_write_data[0], port_q[0].addr, port_q[0].data[0]); end
         end else begin
            checks++; if (csr_write_data !== '0) begin failures++; $display("FAIL rnd_wr_idle cyc=%0d got=%h want 0", cyc, csr_write_data); end
         end
         exp_rv = (rsp_q.size() != 0);
         checks++; if (rsp_valid !== exp_rv) begin failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b want=%b", cyc, rsp_valid, exp_rv); end
         if (exp_rv) begin
            exp_d = {NT{rsp_q[0].word}};
            checks++; if (rsp_idx !== rsp_q[0].idx || rsp_uuid !== rsp_q[0].uuid || rsp_wid !== rsp_q[0].wid || rsp_data !== exp_d) begin
               failures++; $display("FAIL rnd_rsp_payload cyc=%0d got idx=%0d d0=%h want idx=%0d d0=%h", cyc, rsp_idx, rsp_data[0], rsp_q[0].idx, rsp_q[0].word); end
         end
         read_ok = !exp_rd && (!exp_rv || rsp_ready);
         g = -1;
         for (int k = 0; k < NR; k++) begin
            i = (m_ptr + k) % NR;
            if (g < 0 && req_valid[i] && (req_rw[i] || read_ok)) g = i;
         end
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rnd_grant cyc=%0d got=%b want=%b", cyc, req_ready, exp_rdy); end
         if (exp_rv && rsp_ready) void'(rsp_q.pop_front());
         if (exp_rd) begin
            r.idx = port_q[0].idx; r.uuid = port_q[0].uuid; r.wid = port_q[0].wid;
            r.word = m_mem[port_q[0].addr[3:0]];
            rsp_q.push_back(r);
         end
         if (exp_wr) m_mem[port_q[0].addr[3:0]] = port_q[0].data[0];
         port_q.delete();
         if (g >= 0) begin
            a.rw = req_rw[g]; a.idx = IB'(g); a.uuid = req_uuid[g]; a.wid = req_wid[g];
            a.tmask = req_tmask[g]; a.addr = req_addr[g]; a.data = req_data[g];
            port_q.push_back(a);
            m_ptr = (g + 1) % NR;
         end
         next_cycle();
      end
      clear_reqs();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      clear_reqs();
      test_reset();
      test_write_rr();
      test_read_basic();
      test_backpressure();
      test_write_then_read();
      test_reset_midflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vx_gpu_csr_arbiter.md
# vx_gpu_csr_arbiter

Shares a single GPU CSR slave (read/write port set: enable, uuid, wid, tmask, addr, data) between `NUM_REQS` requesters, such as the per-warp CSR issue path, the debug/DCR path and the performance sampler. It uses round-robin arbitration and a one-entry registered issue stage to drive the CSR port. It captures combinational read data into a single response buffer with valid/ready back-pressure. It sits between the requesters and the CSR unit's slave port inside the core.

## Interface
- `NUM_REQS`, 4: number of requesters (≥1).
- `NUM_THREADS`, `` `NUM_THREADS ``: lanes per access.
- `NW_BITS`, `` `UP(`NW_BITS) ``: warp-id width.
- `UUID_BITS`, `` `UP(`UUID_BITS) ``: uuid width.
- `ADDR_BITS`, `` `CSR_ADDR_BITS ``: CSR address width.
- `IDX_BITS`, `` `UP(`CLOG2(NUM_REQS)) ``: requester index width.

Ports:
- `clk` in 1: clock. One clock domain.
- `reset` in 1: asynchronous, active-low reset. Asserted when 0.
- `req_valid` in NUM_REQS: request pending, per requester.
- `req_rw` in NUM_REQS: 0 = read, 1 = write.
- `req_uuid` in NUM_REQS×UUID_BITS
- `req_wid` in NUM_REQS×NW_BITS
- `req_tmask` in NUM_REQS×NUM_THREADS
- `req_addr` in NUM_REQS×ADDR_BITS
- `req_data` in NUM_REQS×NUM_THREADS×32: write data. Ignored for reads.
- `req_ready` out NUM_REQS: one-hot grant. Handshake happens when `req_valid[i]&req_ready[i]`.
- `csr_read_enable`, `csr_read_uuid`, `csr_read_wid`, `csr_read_tmask`, `csr_read_addr` out: CSR read port.
- `csr_read_data` in NUM_THREADS×32: combinational read data, valid in the same cycle as `csr_read_enable`.
- `csr_write_enable`, `csr_write_uuid`, `csr_write_wid`, `csr_write_tmask`, `csr_write_addr`, `csr_write_data` out: CSR write port.
- `rsp_valid` out 1: read response available.
- `rsp_idx` out IDX_BITS: requester that issued the read.
- `rsp_uuid`, `rsp_wid` out: echoed from the request.
- `rsp_data` out NUM_THREADS×32: captured read data.
- `rsp_ready` in 1: consumer accepts the response.

## Operation
- Eligibility: `elig[i] = req_valid[i] & (req_rw[i] | read_ok)`.
  - `read_ok = !(stage_valid & !stage_rw) & (!rsp_valid | rsp_ready)`.
- Round-robin: `req_ready` grants the first eligible index at or after `rr_ptr`, wrapping modulo NUM_REQS. At most one grant per cycle.
  - On a grant to index g, `rr_ptr <= (g+1) mod NUM_REQS`.
  - With no grant, `rr_ptr` holds.
  - `req_ready` is combinational from the inputs and state. A requester may drop `req_valid` while not granted.
- Issue stage:
  - Every cycle, the stage loads the granted request (rw, idx, uuid, wid, tmask, addr, data).
  - With no grant it loads a bubble (`stage_valid=0`).
  - The CSR slave has no back-pressure, so the stage never stalls.
- CSR drive, from the stage registers:
  - `csr_read_enable = stage_valid & !stage_rw`.
  - `csr_write_enable = stage_valid & stage_rw`.
  - Read and write payload outputs both mirror the stage fields. `csr_*_data` is zero when its enable is low.
- Response buffer:
  - When `csr_read_enable=1`, capture `csr_read_data`, idx, uuid and wid, and set `rsp_valid`.
  - `rsp_valid & rsp_ready` clears `rsp_valid` unless a capture happens the same cycle. `read_ok` excludes that overlap, so it cannot occur.
  - `rsp_data` holds its value while `rsp_valid` is held.
- Ordering: accesses reach the CSR port in grant order. A write granted at N is visible to a read granted at N+1 or later.
- Writes never wait on the response buffer. Only reads are blocked by a full buffer or an in-flight read.

## Timing
- Reset (async assert, synchronous-safe deassert):
  - `rr_ptr=0`, `stage_valid=0`, `rsp_valid=0`.
  - All `csr_*_enable=0`, `req_ready=0` while reset is held, and `rsp_*` payload = 0.
  - In-flight reads are dropped and produce no response.
- Write latency: handshake at cycle N → `csr_write_enable=1` at N+1.
- Read latency: handshake at N → `csr_read_enable=1` at N+1 → `rsp_valid=1` at N+2.
- Throughput:
  - 1 write per cycle.
  - 1 read per 2 cycles when `rsp_ready` is held at 1.
  - A read and a write interleave as 1 access per cycle.
- Boundaries:
  - Buffer full with `rsp_ready=0`: reads are blocked indefinitely and writes proceed.
  - `rsp_ready=1` in the same cycle as a read grant is allowed: the buffer drains at N and refills at N+1.
  - NUM_REQS=1: `rr_ptr` is constant 0 and `rsp_idx=0`.
  - `rr_ptr` wraps from NUM_REQS-1 to 0.

## Test plan
- Reset held at 0 with all `req_valid=1`: `req_ready=0`, no CSR enables, `rsp_valid=0`. After release, req0 is granted first.
- All 4 requesters issue writes continuously: grants go 0,1,2,3,0 on consecutive cycles, and `csr_write_enable=1` every cycle from the second cycle with matching addr/data.
- Req2 reads addr 0x0C0 with slave data 0xDEADBEEF/lane, `rsp_ready=1`: `csr_read_enable` at N+1, then `rsp_valid`, `rsp_idx=2`, `rsp_data=0xDEADBEEF` at N+2.
- Back-pressure: `rsp_ready=0` with a response pending, req0 read and req1 write pending: req1 is granted immediately and req0 is stalled. Raising `rsp_ready` grants req0 that cycle.
- Req1 writes 0x55 to 0x7C0, then in the next cycle req1 reads 0x7C0: the CSR port sees the write at N+1 and the read at N+2, and the response returns 0x55.
- Assert reset the cycle after a read grant: no `csr_read_enable`, no `rsp_valid` after release, and `rr_ptr=0`.
